// File: rtl/mem_dump_reader_if.sv
// rtl/mem_dump_reader_if.sv - memory read port and byte stream bundle for mem_dump_reader
// Signals:
//   mem_addr  reader -> memory       registered read address
//   mem_data  memory -> reader       read data, one cycle after the address is sampled
//   tx_data   reader -> transmitter  byte, most-significant byte of the word first
//   tx_valid  reader -> transmitter  byte available
//   tx_ready  transmitter -> reader  byte accepted on an edge where tx_valid is also high
// Modports: master = dump reader, slave = memory plus transmitter side.
interface mem_dump_reader_if #(
  parameter int RAM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [RAM_WIDTH-1:0]  mem_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output mem_addr,
    input  mem_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - walks data memory 0..DUMP_WORDS-1 and streams each word out MSB byte first
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   start  dump request, only looked at while idle
//   busy   high in every state except idle
//   done   one-cycle pulse in the final cycle of a dump
//   bus    mem_dump_reader_if.master: mem_addr/mem_data read port, tx_data/tx_valid/tx_ready byte channel
module mem_dump_reader #(
  parameter int RAM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int DUMP_WORDS = 2048
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  mem_dump_reader_if.master bus
);

  localparam int BYTES = RAM_WIDTH / 8;
  localparam int CNT_W = (BYTES == 1) ? 1 : $clog2(BYTES + 1);
  // Termination is an equality compare on the last address, so a full
  // 2^ADDR_WIDTH dump finishes without the counter ever wrapping.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DUMP_WORDS - 1);
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [RAM_WIDTH-1:0]  shift_q, shift_next;
  logic [CNT_W-1:0]      cnt_q, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_next;
      addr_q  <= addr_next;
      shift_q <= shift_next;
      cnt_q   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    addr_next    = addr_q;
    shift_next   = shift_q;
    cnt_next     = cnt_q;
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    bus.tx_valid = (state == S_SEND);
    // Gated by state so the byte lane reads 0x00 whenever nothing is offered.
    bus.tx_data  = (state == S_SEND) ? shift_q[RAM_WIDTH-1 -: 8] : 8'h00;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ADDR;
          addr_next  = '0;
          cnt_next   = '0;
        end
      end
      // Memory samples mem_addr on the edge leaving this state.
      S_ADDR: state_next = S_LATCH;
      // Read data is valid now; capture it on the way out.
      S_LATCH: begin
        shift_next = bus.mem_data;
        state_next = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          shift_next = shift_q << 8;
          cnt_next   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BYTE) begin
            cnt_next = '0;
            if (addr_q == LAST_ADDR) begin
              state_next = S_DONE;
            end else begin
              addr_next  = addr_q + ADDR_WIDTH'(1);
              state_next = S_ADDR;
            end
          end
        end
      end
      S_DONE: begin
        addr_next  = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.mem_addr = addr_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - self-checking bench for mem_dump_reader (4-word and 2048-word instances)
module tb_mem_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, busy_a, done_a;
  logic rst_b, start_b, busy_b, done_b;

  mem_dump_reader_if #(.RAM_WIDTH(16), .ADDR_WIDTH(11)) ifa ();
  mem_dump_reader_if #(.RAM_WIDTH(16), .ADDR_WIDTH(11)) ifb ();

  mem_dump_reader #(.RAM_WIDTH(16), .ADDR_WIDTH(11), .DUMP_WORDS(4)) u_a (
    .clk   (clk),
    .reset (rst_a),
    .start (start_a),
    .busy  (busy_a),
    .done  (done_a),
    .bus   (ifa.master)
  );

  mem_dump_reader #(.RAM_WIDTH(16), .ADDR_WIDTH(11), .DUMP_WORDS(2048)) u_b (
    .clk   (clk),
    .reset (rst_b),
    .start (start_b),
    .busy  (busy_b),
    .done  (done_b),
    .bus   (ifb.master)
  );

  // Synchronous-read memories
  logic [15:0] mem_a [4];
  always @(posedge clk) ifa.mem_data <= mem_a[ifa.mem_addr[1:0]];
  always @(posedge clk) ifb.mem_data <= 16'(ifb.mem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: dump stream is word (k/2) of memory, byte k%2, high byte first
  function automatic logic [7:0] exp_byte(input int id, input int k);
    int n = (id == 0) ? 4 : 2048;
    int w = (k / 2) % n;
    logic [15:0] word = (id == 0) ? mem_a[w] : 16'(w);
    return (k % 2 == 0) ? word[15:8] : word[7:0];
  endfunction

  int          xfer [2]       = '{0, 0};
  int          busy_cnt [2]   = '{0, 0};
  int          stall_cnt [2]  = '{0, 0};
  bit          after_rst [2]  = '{1, 1};
  bit          prev_stall [2] = '{0, 0};
  bit          prev_done [2]  = '{0, 0};
  logic [7:0]  prev_data [2];
  logic [7:0]  log_a [$];
  int          cnt_b = 0;
  logic [7:0]  last_b [2];

  task automatic check_port(input int id, input logic rst, input logic busy, input logic done,
                            input logic tv, input logic tr, input logic [7:0] td,
                            input logic [10:0] ma);
    int n = (id == 0) ? 4 : 2048;
    if (after_rst[id]) begin
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_valid", 32'(tv), 0);
      chk("reset_data", 32'(td), 0);
      chk("reset_addr", 32'(ma), 0);
    end else begin
      if (prev_stall[id]) begin
        chk("stall_valid_held", 32'(tv), 1);
        chk("stall_data_held", 32'(td), 32'(prev_data[id]));
      end
      if (prev_done[id]) chk("done_single_pulse", 32'(done), 0);
      if (!busy) begin
        chk("idle_valid", 32'(tv), 0);
        chk("idle_done", 32'(done), 0);
      end
    end
    if (rst) begin
      after_rst[id]  = 1;
      xfer[id]       = 0;
      busy_cnt[id]   = 0;
      stall_cnt[id]  = 0;
      prev_stall[id] = 0;
      prev_done[id]  = 0;
    end else begin
      after_rst[id] = 0;
      if (busy) busy_cnt[id]++;
      if (tv && !tr) stall_cnt[id]++;
      if (tv && tr) begin
        chk("byte", 32'(td), 32'(exp_byte(id, xfer[id])));
        chk("byte_addr", 32'(ma), 32'((xfer[id] / 2) % n));
        if (id == 0) log_a.push_back(td);
        else begin
          cnt_b++;
          last_b[0] = last_b[1];
          last_b[1] = td;
        end
        xfer[id]++;
      end
      if (done) begin
        chk("busy_cycles", 32'(busy_cnt[id]), 32'(n * 4 + 1 + stall_cnt[id]));
        chk("bytes_per_dump", 32'(xfer[id]), 32'(n * 2));
        chk("done_addr", 32'(ma), 32'(n - 1));
        xfer[id]      = 0;
        busy_cnt[id]  = 0;
        stall_cnt[id] = 0;
      end
      prev_stall[id] = tv && !tr;
      prev_data[id]  = td;
      prev_done[id]  = done;
    end
  endtask

  always @(negedge clk) begin
    check_port(0, rst_a, busy_a, done_a, ifa.tx_valid, ifa.tx_ready, ifa.tx_data, ifa.mem_addr);
    check_port(1, rst_b, busy_b, done_b, ifb.tx_valid, ifb.tx_ready, ifb.tx_data, ifb.mem_addr);
  end

  task automatic wait_done(input int id, input int limit, output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (id == 0 ? busy_a : busy_b) cyc++;
      if (id == 0 ? done_a : done_b) seen = 1;
    end
    chk(id == 0 ? "done_seen_a" : "done_seen_b", 32'(seen), 1);
  endtask

  task automatic check_log8(input string name, input int base);
    logic [7:0] exp8 [8] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      if (base + i < log_a.size()) chk(name, 32'(log_a[base + i]), 32'(exp8[i]));
      else chk(name, 32'hDEAD, 32'(exp8[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit got;
    mem_a[0] = 16'h1234;
    mem_a[1] = 16'hABCD;
    mem_a[2] = 16'h0000;
    mem_a[3] = 16'hFFFF;
    rst_a = 1'b1; start_a = 1'b1; ifa.tx_ready = 1'b1;
    rst_b = 1'b1; start_b = 1'b0; ifb.tx_ready = 1'b1;

    // Reset held 3 cycles with start high
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_busy", 32'(busy_a), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Basic dump: start still high, sampled at the next edge
    log_a.delete();
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(0, 100, cyc);
    chk("basic_busy_17", 32'(cyc), 17);
    chk("basic_count", 32'(log_a.size()), 8);
    check_log8("basic_bytes", 0);

    // Backpressure: 5 stalled cycles, then tx_ready toggling
    @(posedge clk); #1;
    ifa.tx_ready = 1'b0;
    log_a.delete();
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ifa.tx_valid) got = 1;
    end
    chk("bp_valid_seen", 32'(got), 1);
    repeat (4) @(negedge clk);
    chk("bp_stalled_data", 32'(ifa.tx_data), 32'h12);
    chk("bp_stalled_valid", 32'(ifa.tx_valid), 1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1 ifa.tx_ready = ~ifa.tx_ready;
      @(negedge clk);
      if (done_a) got = 1;
    end
    chk("bp_done_seen", 32'(got), 1);
    chk("bp_count", 32'(log_a.size()), 8);
    check_log8("bp_bytes", 0);

    // Start latency, then a start pulse mid-dump is ignored
    @(posedge clk); #1;
    ifa.tx_ready = 1'b1;
    log_a.delete();
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    chk("lat_busy", 32'(busy_a), 1);
    chk("lat_addr", 32'(ifa.mem_addr), 0);
    chk("lat_valid_c1", 32'(ifa.tx_valid), 0);
    @(negedge clk);
    chk("lat_valid_c2", 32'(ifa.tx_valid), 0);
    @(negedge clk);
    chk("lat_valid_c3", 32'(ifa.tx_valid), 1);
    repeat (3) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(0, 100, cyc);
    @(negedge clk);
    chk("midstart_idle", 32'(busy_a), 0);
    chk("midstart_count", 32'(log_a.size()), 8);
    check_log8("midstart_bytes", 0);

    // Start held high: back-to-back dumps with one idle cycle between
    @(posedge clk); #1;
    log_a.delete();
    start_a = 1'b1;
    wait_done(0, 100, cyc);
    @(negedge clk);
    chk("held_gap_idle", 32'(busy_a), 0);
    @(negedge clk);
    chk("held_restart", 32'(busy_a), 1);
    chk("held_restart_addr", 32'(ifa.mem_addr), 0);
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(0, 100, cyc);
    chk("held_count", 32'(log_a.size()), 16);
    check_log8("held_first", 0);
    check_log8("held_second", 8);

    // Reset right after byte AB is accepted
    @(posedge clk); #1;
    log_a.delete();
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ifa.tx_valid && ifa.tx_ready && ifa.tx_data == 8'hAB) got = 1;
    end
    chk("rst_ab_seen", 32'(got), 1);
    @(posedge clk); #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(ifa.tx_valid), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    @(posedge clk); #1;
    log_a.delete();
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(0, 100, cyc);
    chk("midrst_count", 32'(log_a.size()), 8);
    check_log8("midrst_bytes", 0);

    // Full-depth dump on the 2048-word instance
    @(posedge clk); #1;
    cnt_b = 0;
    start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    wait_done(1, 9000, cyc);
    chk("full_busy", 32'(cyc), 32'(2048 * 4 + 1));
    chk("full_count", 32'(cnt_b), 4096);
    chk("full_last_hi", 32'(last_b[0]), 32'h07);
    chk("full_last_lo", 32'(last_b[1]), 32'hFF);
    @(negedge clk);
    chk("full_idle_after", 32'(busy_b), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
